// File: rtl/chaos_pkg.sv
// Shared float-field layout and key types for the chaotic keystream path.
package chaos_pkg;
  localparam int FP_EXP_W      = 8;
  localparam int FP_MAN_W      = 23;
  localparam int FP_BIAS       = 127;
  localparam int KEY_SHIFT_OFS = 118;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  typedef logic [7:0] key_t;
endpackage

// File: rtl/key_fifo.sv
// Synchronous key-byte FIFO; occupancy kept as an explicit counter, head shown as 0 when empty.
module key_fifo
  import chaos_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  key_t             din,
  input  logic             pop,
  output key_t             dout,
  output logic [FIFO_AW:0] level,
  output logic             full,
  output logic             empty
);
  localparam logic [FIFO_AW:0] LVL_FULL = FIFO_DEPTH[FIFO_AW:0];

  key_t               mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/chaos_key_extractor.sv
// Float sample -> Q0.32 fraction -> XOR-folded key byte, buffered on a valid/ready stream.
// Optional KEYGEN_STATS_EN adds saturating key_count/drop_count outputs.
module chaos_key_extractor
  import chaos_pkg::*;
#(
  parameter  int PRECISION  = 32,
  parameter  int FIFO_DEPTH = 8,
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sawtooth_valid,
  input  logic [PRECISION-1:0] sawtooth_result,
  output logic                 key_tvalid,
  input  logic                 key_tready,
  output key_t                 key_byte,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 overflow_err,
  output logic                 nan_err,
  input  logic                 clear_err
`ifdef KEYGEN_STATS_EN
  ,
  output logic [31:0]          key_count,
  output logic [15:0]          drop_count
`endif
);

  // Q0.32 fractional part of |x|; integer part and sign are discarded.
  function automatic logic [31:0] frac_of(input logic [FP_EXP_W-1:0] e,
                                          input logic [FP_MAN_W-1:0] man);
    logic signed [9:0] s;
    logic        [9:0] ns;
    logic       [23:0] m;
    logic       [31:0] wide;
    s    = $signed({2'b00, e}) - 10'sd118;
    ns   = 10'(-s);
    m    = {1'b1, man};
    wide = '0;
    if (e == '0)              wide = '0;
    else if (s >= 10'sd32)    wide = '0;
    else if (s >= 10'sd0)     wide = {8'b0, m} << s[4:0];
    else if (ns >= 10'd24)    wide = '0;
    else                      wide = {8'b0, m >> ns[4:0]};
    return wide;
  endfunction

  function automatic key_t fold(input logic [31:0] f);
    return f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
  endfunction

  fp32_t       smp;
  logic        unused_sign;
  logic        vld_p1;
  logic        bad_p1;
  logic [31:0] frac_p1;
  logic        vld_p2;
  key_t        key_p2;
  logic        pop;
  logic        push;
  logic        drop;
  logic        nan_set;
  logic        fifo_full;
  logic        fifo_empty;

  assign smp         = sawtooth_result;
  assign unused_sign = smp.sign;

  // Stage 1: unpack and align the mantissa
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= sawtooth_valid;
  end

  always_ff @(posedge clk) begin
    bad_p1  <= (smp.exp == '1);
    frac_p1 <= frac_of(smp.exp, smp.man);
  end

  // Stage 2: fold to a byte; bad samples never request a write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1 && !bad_p1;
  end

  always_ff @(posedge clk) begin
    key_p2 <= fold(frac_p1);
  end

  assign key_tvalid = !fifo_empty;
  assign pop        = key_tvalid && key_tready;
  assign drop       = vld_p2 && fifo_full && !pop;
  assign push       = vld_p2 && !drop;
  assign nan_set    = vld_p1 && bad_p1;

  key_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (key_p2),
    .pop   (pop),
    .dout  (key_byte),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky flags: a coincident set beats clear_err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err <= 1'b0;
      nan_err      <= 1'b0;
    end else begin
      overflow_err <= drop    | (overflow_err & ~clear_err);
      nan_err      <= nan_set | (nan_err      & ~clear_err);
    end
  end

`ifdef KEYGEN_STATS_EN
  logic [31:0] key_base;
  logic [32:0] key_sum;
  logic [15:0] drop_base;
  logic [16:0] drop_sum;

  assign key_base  = clear_err ? '0 : key_count;
  assign drop_base = clear_err ? '0 : drop_count;
  assign key_sum   = {1'b0, key_base} + {32'b0, pop};
  assign drop_sum  = {1'b0, drop_base} + {15'b0, drop} + {15'b0, nan_set};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_count  <= '0;
      drop_count <= '0;
    end else begin
      key_count  <= key_sum[32]  ? '1 : key_sum[31:0];
      drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end
`endif

endmodule
